// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter control sequencer with hardware return-address stack
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int PC_STEP     = 2,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [PC_W-1:0] cmd_target,
  input  logic            cmd_cond,
  input  logic            resume,
  input  logic            soft_clr,
  input  logic [PC_W-1:0] pc_dout,
  output logic [PC_W-1:0] pc_din,
  output logic            pc_en,
  output logic            pc_jmp,
  output logic            pc_sync_rst,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [SP_W-1:0] stack_depth
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALTED, S_FAULT} state_t;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  localparam int              IDX_W   = SP_W - 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  state_t            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              push;
  logic              accept;
  logic [SP_W-1:0]   sp_m1;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [PC_W-1:0]   push_addr;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  assign cmd_ready = (state_q == S_RUN) && !soft_clr;
  assign accept    = cmd_valid && cmd_ready;
  assign sp_m1     = sp_q - SP_W'(1);
  assign push_idx  = sp_q[IDX_W-1:0];
  assign pop_idx   = sp_m1[IDX_W-1:0];
  // Return address wraps naturally at the PC width
  assign push_addr = pc_dout + PC_W'(PC_STEP);

  // State, stack pointer and fault code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      sp_q         <= '0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Return-address storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= push_addr;
    end
  end

  // Next-state logic: soft_clr overrides everything except an INIT already in progress
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    fault_code_d = fault_code_q;
    push         = 1'b0;
    if (soft_clr && (state_q != S_INIT)) begin
      state_d      = S_INIT;
      fault_code_d = 2'b00;
    end else begin
      case (state_q)
        S_INIT: begin
          state_d = S_RUN;
          sp_d    = '0;
        end
        S_RUN: begin
          if (accept) begin
            case (cmd_op)
              OP_NEXT, OP_JUMP, OP_BRANCH: ;
              OP_CALL: begin
                if (sp_q == SP_FULL) begin
                  state_d      = S_FAULT;
                  fault_code_d = 2'b01;
                end else begin
                  push = 1'b1;
                  sp_d = sp_q + SP_W'(1);
                end
              end
              OP_RET: begin
                if (sp_q == '0) begin
                  state_d      = S_FAULT;
                  fault_code_d = 2'b10;
                end else begin
                  sp_d = sp_m1;
                end
              end
              OP_HALT: state_d = S_HALTED;
              default: begin
                state_d      = S_FAULT;
                fault_code_d = 2'b11;
              end
            endcase
          end
        end
        S_HALTED: begin
          if (resume) begin
            state_d = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // PC control outputs, combinational from state and the accepted command
  always_comb begin
    pc_en       = 1'b0;
    pc_jmp      = 1'b0;
    pc_din      = cmd_target;
    pc_sync_rst = (state_q == S_INIT);
    if (accept) begin
      case (cmd_op)
        OP_NEXT: pc_en = 1'b1;
        OP_JUMP: begin
          pc_en  = 1'b1;
          pc_jmp = 1'b1;
        end
        OP_BRANCH: begin
          pc_en  = 1'b1;
          pc_jmp = cmd_cond;
        end
        OP_CALL: begin
          pc_en  = (sp_q != SP_FULL);
          pc_jmp = (sp_q != SP_FULL);
        end
        OP_RET: begin
          if (sp_q != '0) begin
            pc_en  = 1'b1;
            pc_jmp = 1'b1;
            pc_din = stack_q[pop_idx];
          end
        end
        default: ;
      endcase
    end
  end

  assign halted      = (state_q == S_HALTED);
  assign fault       = (state_q == S_FAULT);
  assign fault_code  = fault_code_q;
  assign stack_depth = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int STEP  = 2;
  localparam int DEPTH = 16;
  localparam int SP_W  = 5;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = 3'd0;
  logic [PC_W-1:0] cmd_target = '0;
  logic            cmd_cond = 1'b0;
  logic            resume = 1'b0;
  logic            soft_clr = 1'b0;
  logic [PC_W-1:0] pc_dout;
  logic [PC_W-1:0] pc_din;
  logic            pc_en, pc_jmp, pc_sync_rst, halted, fault;
  logic [1:0]      fault_code;
  logic [SP_W-1:0] stack_depth;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .PC_STEP(STEP), .STACK_DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target), .cmd_cond(cmd_cond),
    .resume(resume), .soft_clr(soft_clr), .pc_dout(pc_dout), .pc_din(pc_din),
    .pc_en(pc_en), .pc_jmp(pc_jmp), .pc_sync_rst(pc_sync_rst), .halted(halted),
    .fault(fault), .fault_code(fault_code), .stack_depth(stack_depth)
  );

  // The program counter this block controls
  logic [PC_W-1:0] pc_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc_reg <= '0;
    else if (pc_sync_rst) pc_reg <= '0;
    else if (pc_en)       pc_reg <= pc_jmp ? pc_din : pc_reg + PC_W'(STEP);
  end
  assign pc_dout = pc_reg;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: mode flags, a queue for the stack, integer PC
  bit m_init, m_halted, m_fault;
  int m_fcode;
  int m_pc;
  int m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_halted = 0; m_fault = 0; m_fcode = 0; m_pc = 0;
    m_stack.delete();
  endtask

  // Drive one cycle of inputs, check every output against the model, advance one clock
  task automatic cycle(input bit v, input int op, input int tgt, input bit cond,
                       input bit res, input bit clr);
    bit run, e_ready, acc, e_en, e_jmp;
    int e_din, new_pc;
    cmd_valid = v; cmd_op = op[2:0]; cmd_target = tgt[PC_W-1:0];
    cmd_cond = cond; resume = res; soft_clr = clr;
    #1;
    run     = !m_init && !m_halted && !m_fault;
    e_ready = run && !clr;
    acc     = v && e_ready;
    e_en = 0; e_jmp = 0; e_din = tgt % PC_MOD;
    if (acc) begin
      case (op)
        0: e_en = 1;
        1: begin e_en = 1; e_jmp = 1; end
        2: begin e_en = 1; e_jmp = cond; end
        3: if (m_stack.size() < DEPTH) begin e_en = 1; e_jmp = 1; end
        4: if (m_stack.size() > 0) begin e_en = 1; e_jmp = 1; e_din = m_stack[$]; end
        default: ;
      endcase
    end
    chk("cmd_ready", cmd_ready, e_ready);
    chk("pc_en", pc_en, e_en);
    chk("pc_jmp", pc_jmp, e_jmp);
    chk("pc_din", pc_din, e_din);
    chk("pc_sync_rst", pc_sync_rst, m_init);
    chk("halted", halted, m_halted);
    chk("fault", fault, m_fault);
    chk("fault_code", fault_code, m_fcode);
    chk("stack_depth", stack_depth, m_stack.size());
    chk("pc_dout", pc_dout, m_pc);
    @(posedge clk);
    if (m_init)    new_pc = 0;
    else if (e_en) new_pc = e_jmp ? e_din : (m_pc + STEP) % PC_MOD;
    else           new_pc = m_pc;
    if (clr && !m_init) begin
      m_init = 1; m_halted = 0; m_fault = 0; m_fcode = 0;
    end else if (m_init) begin
      m_init = 0;
      m_stack.delete();
    end else if (acc) begin
      case (op)
        3: if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + STEP) % PC_MOD);
           else begin m_fault = 1; m_fcode = 1; end
        4: if (m_stack.size() > 0) void'(m_stack.pop_back());
           else begin m_fault = 1; m_fcode = 2; end
        5: m_halted = 1;
        6, 7: begin m_fault = 1; m_fcode = 3; end
        default: ;
      endcase
    end else if (m_halted && res) begin
      m_halted = 0;
    end
    m_pc = new_pc;
    @(negedge clk);
  endtask

  typedef struct {
    int op;
    int tgt;
    bit cond;
    int exp_pc;
    int exp_depth;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int r;
    tbl[0]  = '{1, 'h100, 0, 'h100, 0};
    tbl[1]  = '{2, 'h200, 0, 'h102, 0};
    tbl[2]  = '{2, 'h300, 1, 'h300, 0};
    tbl[3]  = '{1, 'h040, 0, 'h040, 0};
    tbl[4]  = '{3, 'h200, 0, 'h200, 1};
    tbl[5]  = '{0, 'h000, 0, 'h202, 1};
    tbl[6]  = '{4, 'h000, 0, 'h042, 0};
    tbl[7]  = '{1, 'h3FE, 0, 'h3FE, 0};
    tbl[8]  = '{3, 'h010, 0, 'h010, 1};
    tbl[9]  = '{3, 'h050, 0, 'h050, 2};
    tbl[10] = '{4, 'h000, 0, 'h012, 1};
    tbl[11] = '{4, 'h000, 0, 'h000, 0};

    // Reset values with a NEXT already presented
    model_reset();
    cmd_valid = 1; cmd_op = 3'd0; cmd_target = 10'h155;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sync_rst", pc_sync_rst, 1);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_jmp", pc_jmp, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_pc_din", pc_din, 10'h155);
    rst_n = 1;

    // Reset release: one INIT cycle, then sequential PC 0, 2, 4, 6
    cycle(1, 0, 0, 0, 0, 0);
    chk("ready_after_init", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_dout, 2 * i);
      chk("sync_rst_once", pc_sync_rst, 0);
      cycle(1, 0, 0, 0, 0, 0);
    end

    // Jump, branch, call/return and wrap-around vectors
    for (int i = 0; i < 12; i++) begin
      cycle(1, tbl[i].op, tbl[i].tgt, tbl[i].cond, 0, 0);
      chk($sformatf("tbl%0d_pc", i), pc_dout, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_depth", i), stack_depth, tbl[i].exp_depth);
    end

    // Fill the stack, then overflow
    for (int i = 0; i < DEPTH; i++) cycle(1, 3, 'h100 + 8 * i, 0, 0, 0);
    chk("full_depth", stack_depth, 16);
    p = pc_dout;
    cycle(1, 3, 'h3C0, 0, 0, 0);
    chk("ovf_fault", fault, 1);
    chk("ovf_code", fault_code, 1);
    chk("ovf_ready", cmd_ready, 0);
    chk("ovf_pc_held", pc_dout, p);
    chk("ovf_depth", stack_depth, 16);
    cycle(1, 0, 0, 0, 1, 0);
    chk("ovf_resume_ignored", fault, 1);
    cycle(1, 0, 0, 0, 0, 1);
    chk("clr_code", fault_code, 0);
    chk("clr_init", pc_sync_rst, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("clr_pc", pc_dout, 0);
    chk("clr_depth", stack_depth, 0);

    // Underflow, then illegal op in a fresh run
    cycle(1, 4, 0, 0, 0, 0);
    chk("udf_code", fault_code, 2);
    cycle(1, 0, 0, 0, 1, 0);
    chk("udf_resume_ignored", fault_code, 2);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 7, 'h123, 0, 0, 0);
    chk("ill_code", fault_code, 3);
    cycle(1, 0, 0, 0, 1, 0);
    chk("ill_resume_ignored", fault, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // HALT with valid held; same-cycle resume has no effect
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 1, 0);
    chk("halt_entered", halted, 1);
    p = pc_dout;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      chk("halt_held", halted, 1);
      chk("halt_pc_frozen", pc_dout, p);
    end
    cycle(1, 0, 0, 0, 1, 0);
    chk("resume_left", halted, 0);
    chk("resume_pc", pc_dout, p);
    cycle(1, 0, 0, 0, 0, 0);
    chk("resume_next_accepted", pc_dout, (p + 2) % PC_MOD);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      cycle($urandom_range(0, 3) != 0,
            (r < 30) ? 0 : (r < 40) ? 1 : (r < 50) ? 2 : (r < 70) ? 3 :
            (r < 88) ? 4 : (r < 93) ? 5 : $urandom_range(6, 7),
            $urandom_range(0, PC_MOD - 1), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0,
            m_fault ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset mid-run
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 3, 'h080, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cmd_valid = 1; cmd_op = 3'd1; cmd_target = 10'h2AA;
    rst_n = 0;
    #1;
    chk("mid_rst_sync_rst", pc_sync_rst, 1);
    chk("mid_rst_pc_en", pc_en, 0);
    chk("mid_rst_pc_jmp", pc_jmp, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_depth", stack_depth, 0);
    chk("mid_rst_pc", pc_dout, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_fault", fault, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
